// File: rtl/player_motion.sv
// Player-ship controller: clamped fixed-step movement with focus mode and an
// ALIVE/INVULN/DEAD life state machine driving blink and dead indications.
module player_motion #(
    parameter int W            = 10,
    parameter int X_MIN        = 20,
    parameter int X_MAX        = 425,
    parameter int Y_MIN        = 25,
    parameter int Y_MAX        = 455,
    parameter int X_START      = 220,
    parameter int Y_START      = 360,
    parameter int FAST_STEP    = 10,
    parameter int SLOW_STEP    = 4,
    parameter int LIVES        = 3,
    parameter int INVULN_TICKS = 32
) (
    input  logic         clk22,
    input  logic         rst,
    input  logic         gameover,
    input  logic [3:0]   btnstate,
    input  logic         focus,
    input  logic         hit,
    output logic [W-1:0] posx,
    output logic [W-1:0] posy,
    output logic [2:0]   lives,
    output logic         invuln,
    output logic         blink,
    output logic         dead
);
    typedef enum logic [1:0] {
        ALIVE  = 2'b00,
        INVULN = 2'b01,
        DEAD   = 2'b10
    } state_t;

    localparam logic [W-1:0] X_MIN_L   = W'(X_MIN);
    localparam logic [W-1:0] X_MAX_L   = W'(X_MAX);
    localparam logic [W-1:0] Y_MIN_L   = W'(Y_MIN);
    localparam logic [W-1:0] Y_MAX_L   = W'(Y_MAX);
    localparam logic [W-1:0] X_START_L = W'(X_START);
    localparam logic [W-1:0] Y_START_L = W'(Y_START);
    localparam logic [W-1:0] FAST_L    = W'(FAST_STEP);
    localparam logic [W-1:0] SLOW_L    = W'(SLOW_STEP);
    localparam logic [2:0]   LIVES_L   = 3'(LIVES);
    localparam logic [7:0]   TICKS_L   = 8'(INVULN_TICKS);

    // Extra bit keeps MIN+s and pos+s from wrapping near the range ends.
    function automatic logic [W-1:0] dec_clamp(input logic [W-1:0] pos,
                                               input logic [W-1:0] step,
                                               input logic [W-1:0] lim);
        logic [W-1:0] res;
        if ({1'b0, pos} >= ({1'b0, lim} + {1'b0, step})) begin
            res = pos - step;
        end else begin
            res = lim;
        end
        return res;
    endfunction

    function automatic logic [W-1:0] inc_clamp(input logic [W-1:0] pos,
                                               input logic [W-1:0] step,
                                               input logic [W-1:0] lim);
        logic [W-1:0] res;
        if (({1'b0, pos} + {1'b0, step}) <= {1'b0, lim}) begin
            res = pos + step;
        end else begin
            res = lim;
        end
        return res;
    endfunction

    state_t       state_r, state_s;
    logic [7:0]   cnt_r, cnt_s;
    logic [W-1:0] step_s, movx_s, movy_s, posx_s, posy_s;
    logic [2:0]   lives_s;

    // Candidate moved position for this tick, independent per axis.
    always_comb begin
        step_s = focus ? SLOW_L : FAST_L;
        case (btnstate[1:0])
            2'b10:   movx_s = dec_clamp(posx, step_s, X_MIN_L);
            2'b01:   movx_s = inc_clamp(posx, step_s, X_MAX_L);
            default: movx_s = posx;
        endcase
        case (btnstate[3:2])
            2'b10:   movy_s = dec_clamp(posy, step_s, Y_MIN_L);
            2'b01:   movy_s = inc_clamp(posy, step_s, Y_MAX_L);
            default: movy_s = posy;
        endcase
    end

    // Life state machine: next state, position, lives and invuln counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        posx_s  = posx;
        posy_s  = posy;
        lives_s = lives;
        case (state_r)
            ALIVE: begin
                if (hit) begin
                    if (lives == 3'd1) begin
                        state_s = DEAD;
                        lives_s = 3'd0;
                    end else begin
                        state_s = INVULN;
                        lives_s = lives - 3'd1;
                        posx_s  = X_START_L;
                        posy_s  = Y_START_L;
                        cnt_s   = TICKS_L;
                    end
                end else begin
                    posx_s = movx_s;
                    posy_s = movy_s;
                end
            end
            INVULN: begin
                posx_s = movx_s;
                posy_s = movy_s;
                if (cnt_r == 8'd1) begin
                    state_s = ALIVE;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            DEAD: begin
                state_s = DEAD;
            end
            default: begin
                state_s = ALIVE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // State and output registers; gameover restarts exactly like rst.
    always_ff @(posedge clk22) begin
        if (rst || gameover) begin
            state_r <= ALIVE;
            cnt_r   <= 8'd0;
            posx    <= X_START_L;
            posy    <= Y_START_L;
            lives   <= LIVES_L;
            invuln  <= 1'b0;
            blink   <= 1'b0;
            dead    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            posx    <= posx_s;
            posy    <= posy_s;
            lives   <= lives_s;
            invuln  <= (state_s == INVULN);
            blink   <= (state_s == INVULN) & cnt_s[2];
            dead    <= (state_s == DEAD);
        end
    end
endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion with hand-computed expectations.
module tb_player_motion;
    logic       clk22 = 1'b0;
    logic       rst = 1'b1;
    logic       gameover = 1'b0;
    logic [3:0] btnstate = 4'b0000;
    logic       focus = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] posx, posy;
    logic [2:0] lives;
    logic       invuln, blink, dead;

    int checks = 0;
    int errors = 0;

    player_motion dut (
        .clk22(clk22), .rst(rst), .gameover(gameover), .btnstate(btnstate),
        .focus(focus), .hit(hit), .posx(posx), .posy(posy), .lives(lives),
        .invuln(invuln), .blink(blink), .dead(dead)
    );

    always #5 clk22 = ~clk22;

    task automatic tick();
        @(posedge clk22);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, int'(posx), ex);
        check({tag, "_y"}, int'(posy), ey);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int ey;
        logic [7:0] c;

        // Reset state
        do_reset();
        check_pos("reset", 220, 360);
        check("reset_lives", int'(lives), 3);
        check("reset_invuln", int'(invuln), 0);
        check("reset_blink", int'(blink), 0);
        check("reset_dead", int'(dead), 0);

        // Hold up at fast step down to the Y_MIN clamp
        btnstate = 4'b1000;
        ey = 360;
        for (int i = 0; i < 40; i++) begin
            tick();
            ey = (ey >= 35) ? ey - 10 : 25;
            check_pos("up_fast", 220, ey);
        end

        // Focus diagonal up-right, then both axes conflicting/holding
        do_reset();
        btnstate = 4'b1001;
        focus = 1'b1;
        tick(); tick(); tick();
        check_pos("focus_diag", 232, 348);
        btnstate = 4'b1100;
        tick();
        check_pos("hold_11_00", 232, 348);

        // Right clamp at X_MAX, then focus step left
        do_reset();
        focus = 1'b0;
        btnstate = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        check_pos("right_420", 420, 360);
        tick();
        check_pos("right_clamp", 425, 360);
        tick();
        check_pos("right_stay", 425, 360);
        btnstate = 4'b0010;
        focus = 1'b1;
        tick();
        check_pos("left_focus", 421, 360);

        // Move to (300,100), then take a hit with lives=3
        do_reset();
        focus = 1'b0;
        btnstate = 4'b1001;
        for (int i = 0; i < 8; i++) tick();
        btnstate = 4'b1000;
        for (int i = 0; i < 18; i++) tick();
        check_pos("pre_hit", 300, 100);
        btnstate = 4'b0000;
        hit = 1'b1;
        tick();
        check_pos("respawn", 220, 360);
        check("hit1_lives", int'(lives), 2);
        check("hit1_invuln", int'(invuln), 1);
        check("hit1_blink", int'(blink), 0);
        // Hit held through the invulnerability window is ignored
        for (int k = 1; k < 32; k++) begin
            tick();
            c = 8'(32 - k);
            check("inv_lives", int'(lives), 2);
            check("inv_invuln", int'(invuln), 1);
            check("inv_blink", int'(blink), int'(c[2]));
        end
        tick();
        check("inv_end", int'(invuln), 0);
        check("inv_end_blink", int'(blink), 0);
        check("inv_end_lives", int'(lives), 2);
        hit = 1'b0;

        // Second hit, wait out invulnerability, move, then fatal hit
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("hit2_lives", int'(lives), 1);
        for (int i = 0; i < 32; i++) tick();
        check("hit2_over", int'(invuln), 0);
        btnstate = 4'b0001;
        tick();
        check_pos("pre_fatal", 230, 360);
        hit = 1'b1;
        tick();
        check_pos("fatal_frozen", 230, 360);
        check("fatal_lives", int'(lives), 0);
        check("fatal_dead", int'(dead), 1);
        check("fatal_invuln", int'(invuln), 0);
        btnstate = 4'b1010;
        for (int i = 0; i < 5; i++) tick();
        check_pos("dead_hold", 230, 360);
        check("dead_hold_lives", int'(lives), 0);
        check("dead_hold_dead", int'(dead), 1);
        hit = 1'b0;
        btnstate = 4'b0000;
        gameover = 1'b1;
        tick();
        gameover = 1'b0;
        check_pos("gameover", 220, 360);
        check("gameover_lives", int'(lives), 3);
        check("gameover_dead", int'(dead), 0);

        // Hit coincident with gameover: restart wins
        gameover = 1'b1;
        hit = 1'b1;
        tick();
        gameover = 1'b0;
        hit = 1'b0;
        check("go_hit_lives", int'(lives), 3);
        check("go_hit_invuln", int'(invuln), 0);

        // rst in mid-INVULN with counter at 10
        hit = 1'b1;
        tick();
        hit = 1'b0;
        for (int i = 0; i < 22; i++) tick();
        check("mid_inv", int'(invuln), 1);
        check("mid_inv_lives", int'(lives), 2);
        do_reset();
        check("rst_inv", int'(invuln), 0);
        check("rst_blink", int'(blink), 0);
        check("rst_lives", int'(lives), 3);
        // State is ALIVE with counter cleared: a hit now takes a full window
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("post_rst_hit_lives", int'(lives), 2);
        check("post_rst_hit_inv", int'(invuln), 1);
        for (int i = 0; i < 31; i++) tick();
        check("post_rst_window", int'(invuln), 1);
        tick();
        check("post_rst_window_end", int'(invuln), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
